// File: rtl/ssds_pkg.sv
// ssds_pkg: shared scan state, polarity helper and slot length for the SSD driver
package ssds_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_e;
  localparam bit ACTIVE_LOW_DEFAULT = 1'b1;
  function automatic int slot_len(input int clk_freq, input int scan_hz);
    return clk_freq / scan_hz;
  endfunction
  function automatic logic [6:0] off_level(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction
endpackage

// File: rtl/ssds_scan_driver.sv
// ssds_scan_driver: time-multiplexed 4-digit seven-segment scan with blanking and frame snapshot
module ssds_scan_driver
  import ssds_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int ACTIVE_LOW   = int'(ACTIVE_LOW_DEFAULT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] digit_0,
  input  logic [6:0] digit_1,
  input  logic [6:0] digit_2,
  input  logic [6:0] digit_3,
  input  logic [3:0] dots,
  output logic [6:0] seg_out,
  output logic       dot_out,
  output logic [3:0] digit_sel,
  output logic       frame_start
);
  localparam int SLOT = slot_len(CLK_FREQ, SCAN_HZ);
  localparam int CW = $clog2(SLOT);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END = CW'(SLOT - 1);
  localparam logic [6:0] OFF = off_level(ACTIVE_LOW != 0);
  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0][6:0] snap_q, snap_d;
  logic [3:0] snap_dot_q, snap_dot_d;
  logic frame_start_q, frame_start_d;
  logic [6:0] seg_out_q, seg_out_d;
  logic dot_out_q, dot_out_d;
  logic [3:0] digit_sel_q, digit_sel_d;
  logic load, drive;
  // next-state, snapshot capture and registered output values derived from the next state
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    load = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d = '0;
      idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d = '0;
          idx_d = '0;
          load = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == BLANK_END) ? DRIVE : BLANK;
        end
        default: begin
          cnt_d = (cnt_q == SLOT_END) ? '0 : cnt_q + 1'b1;
          idx_d = (cnt_q == SLOT_END) ? idx_q + 2'd1 : idx_q;
          state_d = (cnt_q == SLOT_END) ? BLANK : DRIVE;
          load = (cnt_q == SLOT_END) && (idx_q == 2'd3);
        end
      endcase
    end
    snap_d = load ? {digit_3, digit_2, digit_1, digit_0} : snap_q;
    snap_dot_d = load ? dots : snap_dot_q;
    frame_start_d = load;
    drive = (state_d == DRIVE);
    seg_out_d = OFF ^ (drive ? snap_d[idx_d] : 7'd0);
    dot_out_d = OFF[0] ^ (drive & snap_dot_d[idx_d]);
    digit_sel_d = OFF[3:0] ^ (drive ? 4'(4'd1 << idx_d) : 4'd0);
  end
  // state, snapshot and output registers with asynchronous reset to the inactive display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      snap_q <= '0;
      snap_dot_q <= '0;
      frame_start_q <= 1'b0;
      seg_out_q <= OFF;
      dot_out_q <= OFF[0];
      digit_sel_q <= OFF[3:0];
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
      snap_dot_q <= snap_dot_d;
      frame_start_q <= frame_start_d;
      seg_out_q <= seg_out_d;
      dot_out_q <= dot_out_d;
      digit_sel_q <= digit_sel_d;
    end
  end
  assign seg_out = seg_out_q;
  assign dot_out = dot_out_q;
  assign digit_sel = digit_sel_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_ssds_scan_driver.sv
// tb_ssds_scan_driver: scoreboard bench comparing every cycle against a frame-phase reference model
module tb_ssds_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [6:0] digit_0 = '0, digit_1 = '0, digit_2 = '0, digit_3 = '0;
  logic [3:0] dots = '0;
  logic [6:0] seg_out;
  logic dot_out;
  logic [3:0] digit_sel;
  logic frame_start;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  bit m_active = 1'b0;
  int m_phase = 0;
  logic [6:0] m_dig[4];
  logic [3:0] m_dot = '0;
  localparam logic [15:0] OFF_VEC = {3'b000, 1'b0, 1'b1, 4'hF, 7'h7F};

  ssds_scan_driver #(
    .CLK_FREQ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .dots(dots), .seg_out(seg_out), .dot_out(dot_out),
    .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs();
    return {3'b000, frame_start, dot_out, digit_sel, seg_out};
  endfunction

  // reference: one 40-cycle frame, 10-cycle slots, first 2 cycles of each slot blank
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_phase = 0;
      exp_q.delete();
    end else begin
      logic fs;
      int d;
      fs = 1'b0;
      if (!en) begin
        m_active = 1'b0;
        m_phase = 0;
      end else begin
        if (!m_active) begin
          m_active = 1'b1;
          m_phase = 0;
        end else m_phase = (m_phase + 1) % 40;
        if (m_phase == 0) begin
          m_dig[0] = digit_0; m_dig[1] = digit_1; m_dig[2] = digit_2; m_dig[3] = digit_3;
          m_dot = dots;
          fs = 1'b1;
        end
      end
      d = m_phase / 10;
      if (!m_active || (m_phase % 10) < 2) exp_q.push_back({3'b000, fs, 1'b1, 4'hF, 7'h7F});
      else exp_q.push_back({3'b000, fs, ~m_dot[d], ~(4'b0001 << d), ~m_dig[d]});
    end
  end

  // scoreboard pop and single-select invariant, sampled away from the active edge
  always @(negedge clk) begin
    chk("sel_one_low", 16'($countones(~digit_sel) <= 1), 16'd1);
    if (exp_q.size() != 0) chk("scan", obs(), exp_q.pop_front());
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (!(m_active && m_phase == p) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("wait_timeout", 16'(k), 16'd0);
  endtask

  initial begin
    run(3);
    chk("reset_out", obs(), OFF_VEC);
    rst = 1'b0;
    run(3);
    chk("idle_out", obs(), OFF_VEC);
    digit_0 = 7'h3F; digit_1 = 7'h06; digit_2 = 7'h06; digit_3 = 7'h4F; dots = 4'b0000;
    en = 1'b1;
    run(45);
    dots = 4'b1010;
    wait_phase(15);
    digit_2 = 7'h5B;
    run(80);
    wait_phase(35);
    en = 1'b0;
    run(3);
    chk("en_drop_out", obs(), OFF_VEC);
    en = 1'b1;
    run(15);
    wait_phase(25);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_out", obs(), OFF_VEC);
    @(negedge clk);
    chk("rst_hold_out", obs(), OFF_VEC);
    rst = 1'b0;
    run(25);
    for (int i = 0; i < 4; i++) begin
      wait_phase(20);
      digit_0 = 7'($urandom); digit_1 = 7'($urandom);
      digit_2 = 7'($urandom); digit_3 = 7'($urandom);
      dots = 4'($urandom);
    end
    run(45);
    en = 1'b0;
    run(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssds_scan_driver.md
SSDS_SCAN_DRIVER -- requirements
Module: ssds_scan_driver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, meaning per-digit slot rate in Hz; SLOT = CLK_FREQ/SCAN_HZ cycles.
REQ-003 SHALL have parameter BLANK_CYCLES, default 64, meaning dead cycles at the start of each slot; legal only if 1 <= BLANK_CYCLES < SLOT.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 drives segment, dot and select lines active-low.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port en  input  1  display enable, from the SSD bus interface ctrl_en.
REQ-008 SHALL have ports digit_0..digit_3  input  7 each  segment patterns, bit0 = segment a ... bit6 = segment g, 1 = lit.
REQ-009 SHALL have port dots  input  4  decimal points, bit i belongs to digit i, 1 = lit.
REQ-010 SHALL have port seg_out  output  7  physical segment lines.
REQ-011 SHALL have port dot_out  output  1  physical decimal-point line.
REQ-012 SHALL have port digit_sel  output  4  physical digit select lines, one-hot when driving.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-014 SHALL implement the FSM states IDLE, BLANK and DRIVE, plus a slot counter of width clog2(SLOT) and a 2-bit digit index.
REQ-015 In IDLE, seg_out, dot_out and digit_sel SHALL be inactive and the digit index SHALL be held at 0.
REQ-016 IDLE->BLANK SHALL occur when en=1 is sampled; that transition captures the snapshot.
REQ-017 BLANK SHALL keep all outputs inactive for exactly BLANK_CYCLES cycles, then go to DRIVE.
REQ-018 DRIVE SHALL last SLOT-BLANK_CYCLES cycles, with digit_sel bit[index], seg_out = snapshot digit[index] and dot_out = snapshot dots[index], all at ACTIVE_LOW polarity.
REQ-019 At the end of DRIVE, the index SHALL increment modulo 4 and the FSM SHALL return to BLANK; the slot period is exactly SLOT cycles.
REQ-020 Snapshot registers (4x7 digits, 4 dots) SHALL load only on entry to BLANK with index 0; input changes mid-frame SHALL NOT appear until the next frame (no tearing).
REQ-021 frame_start SHALL be 1 for exactly the cycle in which the snapshot is loaded.
REQ-022 en=0 sampled in any state SHALL move the FSM to IDLE on the next edge, with outputs inactive that same edge, the index cleared and the counter cleared.
REQ-023 All outputs SHALL be registered with no combinational path from inputs to outputs; the output value in a cycle SHALL correspond to the state held in that cycle.
REQ-024 Digit selects SHALL never have more than one active line, and SHALL never be active in the cycle a select changes (BLANK guarantees this).

Reset
REQ-025 rst SHALL force the following immediately and asynchronously: state IDLE, counter 0, index 0, snapshot 0, frame_start 0, and seg_out/dot_out/digit_sel inactive (all ones if ACTIVE_LOW=1, else all zeros).
REQ-026 Reset released mid-frame SHALL restart from IDLE, with no partial slot emitted.

Structure
REQ-027 Shared package ssds_pkg SHALL hold the scan state enum, the polarity helper constant and the SLOT computation.
REQ-028 The block SHALL be single-module with no sub-modules, and SHALL be instantiated directly after ssds_bus_interface, consuming ctrl_en, ctrl_digit_0..3 and ctrl_dots.

Verification (CLK_FREQ=1000, SCAN_HZ=100 -> SLOT=10, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-029 Reset then en=1, digit_0=7'h3F, dots=0 -> frame_start pulses once; digit_sel=4'b1111 for 2 cycles, then 4'b1110 with seg_out=7'h40 for 8 cycles.
REQ-030 Free run with en=1 -> digit_sel sequence 1110,1101,1011,0111 repeats every 40 cycles; frame_start period is 40 cycles.
REQ-031 Change digit_2 from 7'h06 to 7'h5B while index=1 -> index 2 still shows ~7'h06; next frame shows ~7'h5B.
REQ-032 en dropped during DRIVE of index 3 -> next cycle all outputs are all-ones and the state is IDLE; en reasserted -> digit 0 shown after 2 blank cycles.
REQ-033 rst asserted mid-DRIVE -> outputs go all-ones before the next clk edge; after release with en=1, the first slot is a full 10 cycles.
REQ-034 dots=4'b1010 -> dot_out=0 only during DRIVE of digits 1 and 3; digit_sel is never zero-hot-violating, and at most one line is low, checked by assertion throughout.
